// File: rtl/ram_io_responder_pkg.sv
// rtl/ram_io_responder_pkg.sv - shared constants and types for ram_io_responder
// Purpose: IO map addresses, IO region tag and the TX FSM state type.
// Ports: none (package).
package ram_io_responder_pkg;

  localparam logic [17:0] IO_BASE      = 18'h30000;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  // in_addr[17:16] value that selects the IO region instead of RAM
  localparam logic [1:0]  IO_REGION    = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/ram_io_responder_resp_tx_fifo.sv
// rtl/ram_io_responder_resp_tx_fifo.sv - synchronous TX byte FIFO
// Purpose: circular FIFO holding output bytes until the TX FSM drains them.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push, push_data    write request and data; push_ok says it was accepted
//   pop                remove head (never asserted when empty)
//   head               current head entry
//   full, empty, count occupancy status
module resp_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ok,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;

  // A push into a full FIFO still lands when the head leaves at the same edge:
  // the write slot then equals the slot being vacated.
  assign push_ok = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte-wide memory bus responder with RAM and IO map
// Purpose: 2^ADDR_WIDTH bytes of RAM (1-cycle read), UART-style in/out bytes at
//   0x30000, cycle clock / program stop at 0x30004, paced TX byte drain.
// Optional: define RESPONDER_RAM_INIT_EN to preload RAM from INIT_FILE.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   in_addr, in_wr, in_data CPU bus (every cycle is a read or a write)
//   out_data                registered read data
//   io_buffer_full          TX FIFO almost full
//   rx_valid, rx_data, rx_ready   input byte handshake
//   tx_valid, tx_data, tx_ready   output byte handshake
//   out_halt, out_overflow  sticky status
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int TX_GAP_CYCLES = 16
`ifdef RESPONDER_RAM_INIT_EN
  ,
  parameter     INIT_FILE     = "test.data"
`endif
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] in_addr,
  input  logic        in_wr,
  input  logic [7:0]  in_data,
  output logic [7:0]  out_data,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        out_halt,
  output logic        out_overflow
);

  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;
  localparam int GW = $clog2(TX_GAP_CYCLES) + 1;

  logic [7:0]  mem [2**ADDR_WIDTH];

  logic [17:0]           addr;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  is_io;
  logic                  io_wr_ok;
  logic                  uart_wr;
  logic                  clk_wr;
  logic                  push;
  logic [7:0]            push_data;
  logic                  push_ok;
  logic                  pop;
  logic [7:0]            head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         occ_next;
  logic [31:0]           cycle_cnt;
  logic [31:0]           snapshot;
  tx_state_t             state;
  logic [GW-1:0]         gap_cnt;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^in_addr[31:18];

  assign addr     = in_addr[17:0];
  assign ram_idx  = in_addr[ADDR_WIDTH-1:0];
  assign is_io    = (addr[17:16] == IO_REGION);

  // After a halt the IO side is frozen; RAM writes keep working.
  assign io_wr_ok = is_io && in_wr && !out_halt;
  assign uart_wr  = io_wr_ok && (addr == IO_UART_ADDR);
  assign clk_wr   = io_wr_ok && (addr == IO_CLK_ADDR);

  // Zero bytes from the program are filtered; the halt terminator is a forced 0x00.
  assign push      = (uart_wr && (in_data != 8'h00)) || clk_wr;
  assign push_data = clk_wr ? 8'h00 : in_data;

  assign rx_ready  = !in_wr && is_io && (addr == IO_UART_ADDR);
  assign pop       = (state == TX_SEND) && tx_ready;
  assign occ_next  = fifo_count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

  resp_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (push_data),
    .push_ok   (push_ok),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (in_wr && !is_io) mem[ram_idx] <= in_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_data       <= 8'h00;
      io_buffer_full <= 1'b0;
      out_halt       <= 1'b0;
      out_overflow   <= 1'b0;
      cycle_cnt      <= 32'h0;
      snapshot       <= 32'h0;
    end else begin
      cycle_cnt      <= cycle_cnt + 32'h1;
      // Asserted one entry early so a write already in flight still fits.
      io_buffer_full <= (occ_next >= CW'(TX_FIFO_DEPTH - 1));
      if (push && !push_ok) out_overflow <= 1'b1;
      if (clk_wr)           out_halt     <= 1'b1;
      if (!in_wr) begin
        if (!is_io) begin
          out_data <= mem[ram_idx];
        end else begin
          case (addr)
            IO_UART_ADDR:       out_data <= rx_valid ? rx_data : 8'h00;
            IO_CLK_ADDR: begin
              // Freeze the counter so the upper bytes read later match byte 0.
              snapshot <= cycle_cnt;
              out_data <= cycle_cnt[7:0];
            end
            IO_CLK_ADDR + 18'd1: out_data <= snapshot[15:8];
            IO_CLK_ADDR + 18'd2: out_data <= snapshot[23:16];
            IO_CLK_ADDR + 18'd3: out_data <= snapshot[31:24];
            default:            out_data <= 8'h00;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= TX_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_valid <= 1'b1;
            tx_data  <= head;
            state    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            gap_cnt  <= GW'(TX_GAP_CYCLES - 1);
            state    <= TX_GAP;
          end
        end
        TX_GAP: begin
          if (gap_cnt == '0) state <= TX_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb/tb_ram_io_responder.sv - scoreboard testbench for ram_io_responder
module tb_ram_io_responder;

  localparam int GAP   = 16;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] in_addr = 32'h0;
  logic        in_wr = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [7:0]  out_data;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        out_halt;
  logic        out_overflow;

  int          checks = 0;
  int          errors = 0;
  int          tb_cyc = 0;
  logic [7:0]  tx_q [$];
  logic [7:0]  rd_q [$];
  int          hs_cyc [$];
  logic        rd_chk = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] snap;
  int          hs_before;

  ram_io_responder #(
    .ADDR_WIDTH    (17),
    .TX_FIFO_DEPTH (DEPTH),
    .TX_GAP_CYCLES (GAP)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .in_addr        (in_addr),
    .in_wr          (in_wr),
    .in_data        (in_data),
    .out_data       (out_data),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .out_halt       (out_halt),
    .out_overflow   (out_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle clock: counts rising edges since reset release.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) tb_cyc = 0;
    else        tb_cyc = tb_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 3 time units after the negedge, well away from posedge.
  always @(negedge clk_in) begin
    #3;
    if (rd_pend && rd_q.size() > 0) check("read_data", {24'h0, out_data}, {24'h0, rd_q.pop_front()});
    rd_pend = rd_chk;
    if (!rst_in && tx_valid && tx_ready) begin
      hs_cyc.push_back(tb_cyc);
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic chk, input logic [7:0] exp);
    @(negedge clk_in);
    in_addr = a;
    in_wr   = w;
    in_data = d;
    rd_chk  = chk;
    if (chk) rd_q.push_back(exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus(a, 1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    bus(a, 1'b0, 8'h00, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
    check("rst_halt", {31'h0, out_halt}, 32'h0);
    check("rst_overflow", {31'h0, out_overflow}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // RAM write/read, hold on write, top address, back-to-back reads
    wr(32'h00010, 8'hA5);
    rd(32'h00010, 8'hA5);
    bus(32'h00020, 1'b1, 8'h3C, 1'b1, 8'hA5);
    rd(32'h00020, 8'h3C);
    wr(32'h1FFFF, 8'h5A);
    rd(32'h1FFFF, 8'h5A);
    rd(32'h00010, 8'hA5);
    rd(32'h00020, 8'h3C);

    // Unmapped IO reads 0; zero byte and unmapped writes are ignored
    rd(32'h30008, 8'h00);
    wr(32'h30000, 8'h00);
    wr(32'h30008, 8'h55);

    // Input byte port
    rx_valid = 1'b1;
    rx_data  = 8'h37;
    rd(32'h30000, 8'h37);
    #1 check("rx_ready_valid", {31'h0, rx_ready}, 32'h1);
    @(posedge clk_in);
    #1 rx_valid = 1'b0;
    rd(32'h30000, 8'h00);
    #1 check("rx_ready_empty", {31'h0, rx_ready}, 32'h1);
    rd(32'h00010, 8'hA5);
    #1 check("rx_ready_ram", {31'h0, rx_ready}, 32'h0);

    // "Hi" with inter-byte gap
    tx_ready = 1'b1;
    hs_cyc.delete();
    tx_q.push_back(8'h48);
    tx_q.push_back(8'h69);
    wr(32'h30000, 8'h48);
    wr(32'h30000, 8'h69);
    idle(40);
    check("hi_count", hs_cyc.size(), 32'd2);
    if (hs_cyc.size() == 2)
      check("hi_gap_ok", {31'h0, (hs_cyc[1] - hs_cyc[0]) >= GAP + 2}, 32'h1);

    // Fill FIFO with sink stalled, overflow on 9th, then drain in order
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h10 + 8'(i));
      wr(32'h30000, 8'h10 + 8'(i));
      idle(1);
      #1;
      if (i == 5) check("buf_full_6", {31'h0, io_buffer_full}, 32'h0);
      if (i == 6) check("buf_full_7", {31'h0, io_buffer_full}, 32'h1);
      if (i == 7) check("ovf_before_9", {31'h0, out_overflow}, 32'h0);
    end
    wr(32'h30000, 8'hEE);
    idle(1);
    #1;
    check("ovf_after_9", {31'h0, out_overflow}, 32'h1);
    check("buf_full_9", {31'h0, io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    idle(200);
    check("drain_left", tx_q.size(), 32'd0);
    check("buf_full_drained", {31'h0, io_buffer_full}, 32'h0);

    // Cycle clock snapshot coherence
    idle(300);
    @(negedge clk_in);
    snap    = tb_cyc;
    in_addr = 32'h30004;
    in_wr   = 1'b0;
    in_data = 8'h00;
    rd_chk  = 1'b1;
    rd_q.push_back(snap[7:0]);
    rd(32'h30005, snap[15:8]);
    rd(32'h30006, snap[23:16]);
    rd(32'h30007, snap[31:24]);
    idle(5);
    rd(32'h30005, snap[15:8]);
    idle(1);

    // Halt: terminator emitted, later IO writes ignored, RAM still writable
    idle(40);
    tx_q.push_back(8'h00);
    wr(32'h30004, 8'hFF);
    idle(1);
    #1 check("halt_set", {31'h0, out_halt}, 32'h1);
    wr(32'h30000, 8'h5A);
    wr(32'h00040, 8'h77);
    rd(32'h00040, 8'h77);
    idle(40);
    check("halt_tx_left", tx_q.size(), 32'd0);
    check("ovf_sticky", {31'h0, out_overflow}, 32'h1);

    // Reset clears sticky state; then reset mid-SEND discards pending bytes
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("rst2_halt", {31'h0, out_halt}, 32'h0);
    check("rst2_overflow", {31'h0, out_overflow}, 32'h0);
    check("rst2_out_data", {24'h0, out_data}, 32'h0);
    @(negedge clk_in);
    rst_in   = 1'b0;
    tx_ready = 1'b0;
    wr(32'h30000, 8'h41);
    wr(32'h30000, 8'h42);
    wr(32'h30000, 8'h43);
    idle(3);
    #1 check("send_before_rst", {31'h0, tx_valid}, 32'h1);
    #1 rst_in = 1'b1;
    #1;
    check("rst_async_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_async_buf_full", {31'h0, io_buffer_full}, 32'h0);
    @(negedge clk_in);
    rst_in    = 1'b0;
    tx_ready  = 1'b1;
    hs_before = hs_cyc.size();
    idle(40);
    check("fifo_flushed", hs_cyc.size(), hs_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
